// File: rtl/agc_pkg.sv
// ---------------------------------------------------------------------------
// agc_pkg
// Shared definitions for the AGC loop and its PWM generator:
//   - agc_state_t : loop FSM state encoding (IDLE / TRACK / LOCK)
//   - step_size() : decodes the 2-bit pwm_step code into a step of 1/2/4/8
//   - TH_INIT_DEF / LOCK_CNT_DEF : default threshold and lock depth
// ---------------------------------------------------------------------------
package agc_pkg;

   localparam int TH_INIT_DEF  = 64;
   localparam int LOCK_CNT_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_LOCK  = 2'd2
   } agc_state_t;

   // Step code is a shift amount: 0->1, 1->2, 2->4, 3->8.
   function automatic logic [3:0] step_size(input logic [1:0] code);
      return 4'd1 << code;
   endfunction

endpackage

// File: rtl/pwm_core.sv
// ---------------------------------------------------------------------------
// pwm_core
// Free-running 2**TH_WID-count PWM with a period-aligned shadow threshold.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   th_init      : shadow threshold value loaded while in reset
//   th_w         : working threshold from the loop, sampled at period start
//   pwm_ena      : output enable; counters are held at 0 while low
//   pwm_inv      : output polarity inversion
//   pwm_out      : registered PWM waveform
//   pwm_th_out   : threshold applied to the current period
// ---------------------------------------------------------------------------
module pwm_core #(
   parameter int TH_WID   = 7,
   parameter int PRESCALE = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [TH_WID-1:0] th_init,
   input  logic [TH_WID-1:0] th_w,
   input  logic              pwm_ena,
   input  logic              pwm_inv,
   output logic              pwm_out,
   output logic [TH_WID-1:0] pwm_th_out
);

   localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PSC_W-1:0]  psc;
   logic [TH_WID-1:0] cnt;
   logic              tick;
   logic              load;
   logic [TH_WID-1:0] th_cmp;
   logic              raw;

   assign tick = (psc == PSC_W'(PRESCALE - 1));
   // Period start: first prescale tick of counter value 0.
   assign load = (cnt == '0) && (psc == '0);
   // Compare against the value being loaded so the whole new period
   // (including count 0) uses the new threshold.
   assign th_cmp = load ? th_w : pwm_th_out;
   assign raw    = (cnt < th_cmp);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         psc        <= '0;
         cnt        <= '0;
         pwm_out    <= 1'b0;
         pwm_th_out <= th_init;
      end else begin
         if (load) begin
            pwm_th_out <= th_w;
         end
         if (!pwm_ena) begin
            psc     <= '0;
            cnt     <= '0;
            pwm_out <= 1'b0;
         end else begin
            pwm_out <= raw ^ pwm_inv;
            if (tick) begin
               psc <= '0;
               cnt <= cnt + TH_WID'(1);
            end else begin
               psc <= psc + PSC_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/agc_pwm_gen.sv
// ---------------------------------------------------------------------------
// agc_pwm_gen
// AGC loop controller: steps a threshold toward a target power window on
// each power estimate strobe and drives a PWM toward the gain RC filter.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   pwr_est_dB     : power estimate (dB code), valid when pwr_est_end=1
//   pwr_est_end    : one-cycle strobe qualifying pwr_est_dB
//   agc_en         : loop enable
//   pwr_target     : window centre; pwr_hyst : window half-width
//   pwm_step       : step size code (1/2/4/8)
//   pwm_ena/inv    : PWM enable and polarity
//   pwm_th_ena/in  : manual threshold override and its value
//   pwm_max_val    : upper clamp on the threshold
//   pwm_out        : PWM waveform
//   pwm_th_out     : threshold applied to the current PWM period
//   agc_fix        : loop locked
// The FSM state is held in fsm_state (agc_state_t) for observation.
// ---------------------------------------------------------------------------
module agc_pwm_gen
   import agc_pkg::*;
#(
   parameter int PWR_WID  = 9,
   parameter int TH_WID   = 7,
   parameter int TH_INIT  = TH_INIT_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF,
   parameter int PRESCALE = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [PWR_WID-1:0] pwr_est_dB,
   input  logic               pwr_est_end,
   input  logic               agc_en,
   input  logic [PWR_WID-1:0] pwr_target,
   input  logic [3:0]         pwr_hyst,
   input  logic [1:0]         pwm_step,
   input  logic               pwm_ena,
   input  logic               pwm_inv,
   input  logic               pwm_th_ena,
   input  logic [TH_WID-1:0]  pwm_th_in,
   input  logic [TH_WID-1:0]  pwm_max_val,
   output logic               pwm_out,
   output logic [TH_WID-1:0]  pwm_th_out,
   output logic               agc_fix
);

   localparam int LCNT_W = $clog2(LOCK_CNT + 1);
   localparam logic [PWR_WID:0] PWR_MAX = {1'b0, {PWR_WID{1'b1}}};

   agc_state_t        fsm_state, state_n;
   logic [TH_WID-1:0] th_w, th_n;
   logic [LCNT_W-1:0] lcnt, lcnt_n;

   logic [TH_WID-1:0] th_init;
   logic [TH_WID-1:0] th_ovr;
   logic [PWR_WID:0]  win_lo, win_hi, hi_sum, est_x;
   logic [TH_WID:0]   step, th_sum;
   logic [TH_WID-1:0] th_up, th_dn;
   logic              est_hi, est_lo;
   logic [LCNT_W-1:0] lcnt_inc;

   assign th_init = (TH_WID'(TH_INIT) > pwm_max_val) ? pwm_max_val : TH_WID'(TH_INIT);
   assign th_ovr  = (pwm_th_in > pwm_max_val) ? pwm_max_val : pwm_th_in;

   // Lock window computed one bit wider so neither bound wraps.
   assign hi_sum = {1'b0, pwr_target} + (PWR_WID+1)'(pwr_hyst);
   assign win_hi = (hi_sum > PWR_MAX) ? PWR_MAX : hi_sum;
   assign win_lo = ({1'b0, pwr_target} >= (PWR_WID+1)'(pwr_hyst))
                   ? ({1'b0, pwr_target} - (PWR_WID+1)'(pwr_hyst)) : '0;
   assign est_x  = {1'b0, pwr_est_dB};
   assign est_hi = (est_x > win_hi);
   assign est_lo = (est_x < win_lo);

   // Saturating step in both directions.
   assign step   = (TH_WID+1)'(step_size(pwm_step));
   assign th_sum = {1'b0, th_w} + step;
   assign th_up  = (th_sum > {1'b0, pwm_max_val}) ? pwm_max_val : th_sum[TH_WID-1:0];
   assign th_dn  = ({1'b0, th_w} < step) ? '0 : (th_w - step[TH_WID-1:0]);

   assign lcnt_inc = lcnt + LCNT_W'(1);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fsm_state <= ST_IDLE;
         th_w      <= th_init;
         lcnt      <= '0;
         agc_fix   <= 1'b0;
      end else begin
         fsm_state <= state_n;
         th_w      <= th_n;
         lcnt      <= lcnt_n;
         agc_fix   <= (state_n == ST_LOCK);
      end
   end

   always_comb begin
      state_n = fsm_state;
      th_n    = th_w;
      lcnt_n  = lcnt;

      if (!agc_en || pwm_th_ena) begin
         state_n = ST_IDLE;
         lcnt_n  = '0;
         if (pwm_th_ena) begin
            th_n = th_ovr;
         end
      end else begin
         case (fsm_state)
            ST_IDLE: begin
               state_n = ST_TRACK;
            end
            ST_TRACK: begin
               if (pwr_est_end) begin
                  if (est_hi) begin
                     th_n   = th_dn;
                     lcnt_n = '0;
                  end else if (est_lo) begin
                     th_n   = th_up;
                     lcnt_n = '0;
                  end else begin
                     lcnt_n = lcnt_inc;
                     if (lcnt_inc == LCNT_W'(LOCK_CNT)) begin
                        state_n = ST_LOCK;
                     end
                  end
               end
            end
            ST_LOCK: begin
               if (pwr_est_end && (est_hi || est_lo)) begin
                  state_n = ST_TRACK;
                  lcnt_n  = '0;
                  th_n    = est_hi ? th_dn : th_up;
               end
            end
            default: begin
               state_n = ST_IDLE;
               lcnt_n  = '0;
            end
         endcase
      end

      // A lowered ceiling wins over hold and over any same-cycle step;
      // the override value is already limited to the ceiling.
      if (!pwm_th_ena && (th_w > pwm_max_val)) begin
         th_n = pwm_max_val;
      end
   end

   pwm_core #(
      .TH_WID   (TH_WID),
      .PRESCALE (PRESCALE)
   ) u_pwm_core (
      .clk        (clk),
      .reset_n    (reset_n),
      .th_init    (th_init),
      .th_w       (th_w),
      .pwm_ena    (pwm_ena),
      .pwm_inv    (pwm_inv),
      .pwm_out    (pwm_out),
      .pwm_th_out (pwm_th_out)
   );

endmodule
